// File: rtl/commit_stage.sv
// Commit (writeback) stage for a one- or two-lane in-order core.
// Registers the retiring group, writes the register file, raises a flush
// for the oldest surviving excepting lane, and serialises the debug trace
// so that one instruction is shown per cycle (an extra DRAIN cycle is spent
// when both lanes retire together).
module commit_stage #(
  parameter int          LANES    = 2,
  parameter int          EXC_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input  logic                         clk,
  input  logic                         resetn,

  input  logic                         in_valid,
  output logic                         in_allowin,

  input  logic [LANES-1:0]             in_lane_v,
  input  logic [LANES*32-1:0]          in_pc,
  input  logic [LANES*5-1:0]           in_dest,
  input  logic [LANES-1:0]             in_gr_we,
  input  logic [LANES*32-1:0]          in_result,
  input  logic [LANES*EXC_W-1:0]       in_exc,
  input  logic [LANES-1:0]             in_refetch,
  input  logic [LANES-1:0]             in_ertn,

  output logic [LANES-1:0]             rf_we,
  output logic [LANES*5-1:0]           rf_waddr,
  output logic [LANES*32-1:0]          rf_wdata,

  output logic                         flush,
  output logic                         exc_taken,
  output logic [$clog2(EXC_W)-1:0]     exc_idx,
  output logic                         ertn_flush,
  output logic [31:0]                  epc,
  output logic [31:0]                  refetch_pc,

  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata
);

  localparam int IDX_W = $clog2(EXC_W);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage state
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic               stage_valid_q;
  logic               flush_pend_q;

  logic               lane_v_q   [LANES];
  logic [31:0]        pc_q       [LANES];
  logic [4:0]         dest_q     [LANES];
  logic               gr_we_q    [LANES];
  logic [31:0]        result_q   [LANES];
  logic [EXC_W-1:0]   exc_q      [LANES];
  logic               refetch_q  [LANES];
  logic               ertn_q     [LANES];

  // Last value shown on the trace port, held while nothing retires
  logic [31:0]        dbg_pc_q;
  logic [4:0]         dbg_wnum_q;
  logic [31:0]        dbg_wdata_q;

  // ---------------------------------------------------------------------------
  // Per-lane decode
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]   lane_exc;     // lane carries a real exception vector
  logic [LANES-1:0]   lane_xcpt;    // lane is valid and needs a flush
  logic [LANES-1:0]   raw_we;       // lane wants to write, before cross-lane rules
  logic [LANES-1:0]   lane_we;      // write enable after kill / same-dest rules
  logic [LANES-1:0]   traced;       // lane appears on the trace port

  logic               flush_hit;
  logic               both_traced;
  logic [31:0]        sel_pc;
  logic [EXC_W-1:0]   sel_exc;
  logic               sel_refetch;
  logic               sel_ertn;

  logic               disp_v;
  logic [31:0]        disp_pc;
  logic               disp_we;
  logic [4:0]         disp_wnum;
  logic [31:0]        disp_wdata;

  logic               idle;
  logic               readygo;
  logic               hold;
  logic               flush_exit;
  logic               load_en;
  logic               stage_valid_d;
  logic               flush_pend_d;
  logic [IDX_W-1:0]   exc_idx_d;

  genvar gi;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_exc[gi]  = |exc_q[gi];
      assign lane_xcpt[gi] = stage_valid_q && lane_v_q[gi]
                             && (lane_exc[gi] || refetch_q[gi] || ertn_q[gi]);
      // Refetch/ertn lanes still write; only a real exception blocks the write
      assign raw_we[gi]    = stage_valid_q && lane_v_q[gi] && gr_we_q[gi] && !lane_exc[gi];
      assign rf_we[gi]     = lane_we[gi] && idle;
      assign rf_waddr[gi*5 +: 5]   = dest_q[gi];
      assign rf_wdata[gi*32 +: 32] = result_q[gi];

      // Capture the lane payload when a new group is accepted
      always_ff @(posedge clk) begin
        if (!resetn) begin
          lane_v_q[gi]  <= 1'b0;
          pc_q[gi]      <= RESET_PC;
          dest_q[gi]    <= 5'd0;
          gr_we_q[gi]   <= 1'b0;
          result_q[gi]  <= 32'd0;
          exc_q[gi]     <= '0;
          refetch_q[gi] <= 1'b0;
          ertn_q[gi]    <= 1'b0;
        end else if (load_en) begin
          lane_v_q[gi]  <= in_lane_v[gi];
          pc_q[gi]      <= in_pc[gi*32 +: 32];
          dest_q[gi]    <= in_dest[gi*5 +: 5];
          gr_we_q[gi]   <= in_gr_we[gi];
          result_q[gi]  <= in_result[gi*32 +: 32];
          exc_q[gi]     <= in_exc[gi*EXC_W +: EXC_W];
          refetch_q[gi] <= in_refetch[gi];
          ertn_q[gi]    <= in_ertn[gi];
        end
      end
    end

    if (LANES == 2) begin : g_dual
      logic kill1;
      logic same_dest;
      logic disp_hi;

      // An excepting lane 0 squashes the younger lane entirely
      assign kill1       = lane_xcpt[0];
      assign traced[0]   = stage_valid_q && lane_v_q[0];
      assign traced[1]   = stage_valid_q && lane_v_q[1] && !kill1;

      // Younger lane wins a same-register write; r0 writes are left alone
      assign same_dest   = raw_we[0] && raw_we[1] && !kill1
                           && (dest_q[0] == dest_q[1]) && (dest_q[0] != 5'd0);
      assign lane_we[0]  = raw_we[0] && !same_dest;
      assign lane_we[1]  = raw_we[1] && !kill1;

      assign flush_hit   = lane_xcpt[0] || lane_xcpt[1];
      assign both_traced = traced[0] && traced[1];

      // Oldest excepting lane supplies epc / cause
      assign sel_pc      = lane_xcpt[0] ? pc_q[0]      : pc_q[1];
      assign sel_exc     = lane_xcpt[0] ? exc_q[0]     : exc_q[1];
      assign sel_refetch = lane_xcpt[0] ? refetch_q[0] : refetch_q[1];
      assign sel_ertn    = lane_xcpt[0] ? ertn_q[0]    : ertn_q[1];

      // Trace lane 1 during DRAIN or when lane 0 is not retiring
      assign disp_hi     = (state_q == DRAIN) || !traced[0];
      assign disp_v      = (state_q == DRAIN) ? stage_valid_q : (traced[0] || traced[1]);
      assign disp_pc     = disp_hi ? pc_q[1]     : pc_q[0];
      assign disp_we     = disp_hi ? lane_we[1]  : lane_we[0];
      assign disp_wnum   = disp_hi ? dest_q[1]   : dest_q[0];
      assign disp_wdata  = disp_hi ? result_q[1] : result_q[0];
    end else begin : g_single
      assign traced[0]   = stage_valid_q && lane_v_q[0];
      assign lane_we[0]  = raw_we[0];
      assign flush_hit   = lane_xcpt[0];
      assign both_traced = 1'b0;
      assign sel_pc      = pc_q[0];
      assign sel_exc     = exc_q[0];
      assign sel_refetch = refetch_q[0];
      assign sel_ertn    = ertn_q[0];
      assign disp_v      = traced[0];
      assign disp_pc     = pc_q[0];
      assign disp_we     = lane_we[0];
      assign disp_wnum   = dest_q[0];
      assign disp_wdata  = result_q[0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake and flush
  // ---------------------------------------------------------------------------
  assign idle       = (state_q == IDLE);
  assign readygo    = !(idle && both_traced);
  // After a flush has fired, keep upstream waiting until the drain completes
  assign hold       = flush_pend_q;
  assign in_allowin = !stage_valid_q || (readygo && !hold);

  assign flush      = idle && flush_hit;
  assign exc_taken  = flush && (|sel_exc);
  assign ertn_flush = flush && !(|sel_exc) && sel_ertn;
  assign epc        = flush ? sel_pc : 32'd0;
  assign refetch_pc = (flush && !(|sel_exc) && sel_refetch) ? sel_pc : 32'd0;
  assign exc_idx    = exc_taken ? exc_idx_d : '0;

  // Stage leaves empty after the group that flushed, and takes nothing new
  assign flush_exit    = stage_valid_q && readygo && (flush || flush_pend_q);
  assign load_en       = in_allowin && in_valid && !flush_exit;
  assign stage_valid_d = flush_exit ? 1'b0 : (in_allowin ? in_valid : stage_valid_q);
  assign flush_pend_d  = flush && !readygo;

  // Lowest set bit of the winning exception vector is the highest priority cause
  always_comb begin
    exc_idx_d = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (sel_exc[i]) begin
        exc_idx_d = i[IDX_W-1:0];
      end
    end
  end

  // Occupancy and IDLE/DRAIN sequencing
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_valid_q <= 1'b0;
      state_q       <= IDLE;
      flush_pend_q  <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      flush_pend_q  <= flush_pend_d;
      if (state_q == IDLE) begin
        if (both_traced) begin
          state_q <= DRAIN;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debug trace
  // ---------------------------------------------------------------------------
  // Remember the last traced instruction so the port holds when idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dbg_pc_q    <= RESET_PC;
      dbg_wnum_q  <= 5'd0;
      dbg_wdata_q <= 32'd0;
    end else if (disp_v) begin
      dbg_pc_q    <= disp_pc;
      dbg_wnum_q  <= disp_wnum;
      dbg_wdata_q <= disp_wdata;
    end
  end

  assign debug_wb_pc       = disp_v ? disp_pc    : dbg_pc_q;
  assign debug_wb_rf_we    = (disp_v && disp_we) ? 4'hf : 4'h0;
  assign debug_wb_rf_wnum  = disp_v ? disp_wnum  : dbg_wnum_q;
  assign debug_wb_rf_wdata = disp_v ? disp_wdata : dbg_wdata_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage (two lanes, 16-bit exception vectors).
// A table of retiring groups with hand-computed results is replayed, then a
// few multi-cycle sequences cover flush-discard and reset during DRAIN.
module tb_commit_stage;

  localparam int LANES = 2;
  localparam int EXC_W = 16;

  logic                   clk;
  logic                   resetn;
  logic                   in_valid;
  logic                   in_allowin;
  logic [LANES-1:0]       in_lane_v;
  logic [LANES*32-1:0]    in_pc;
  logic [LANES*5-1:0]     in_dest;
  logic [LANES-1:0]       in_gr_we;
  logic [LANES*32-1:0]    in_result;
  logic [LANES*EXC_W-1:0] in_exc;
  logic [LANES-1:0]       in_refetch;
  logic [LANES-1:0]       in_ertn;
  logic [LANES-1:0]       rf_we;
  logic [LANES*5-1:0]     rf_waddr;
  logic [LANES*32-1:0]    rf_wdata;
  logic                   flush;
  logic                   exc_taken;
  logic [3:0]             exc_idx;
  logic                   ertn_flush;
  logic [31:0]            epc;
  logic [31:0]            refetch_pc;
  logic [31:0]            debug_wb_pc;
  logic [3:0]             debug_wb_rf_we;
  logic [4:0]             debug_wb_rf_wnum;
  logic [31:0]            debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  commit_stage #(.LANES(LANES), .EXC_W(EXC_W), .RESET_PC(32'h1bfffffc)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allowin(in_allowin),
    .in_lane_v(in_lane_v), .in_pc(in_pc), .in_dest(in_dest), .in_gr_we(in_gr_we),
    .in_result(in_result), .in_exc(in_exc), .in_refetch(in_refetch), .in_ertn(in_ertn),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .exc_taken(exc_taken), .exc_idx(exc_idx), .ertn_flush(ertn_flush),
    .epc(epc), .refetch_pc(refetch_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  lane_v;
    logic [31:0] pc0, pc1;
    logic [4:0]  d0, d1;
    logic [1:0]  gr_we;
    logic [31:0] r0, r1;
    logic [15:0] x0, x1;
    logic [1:0]  refetch, ertn;
    logic [1:0]  e_we;
    logic        e_flush, e_taken;
    logic [3:0]  e_idx;
    logic        e_ertn;
    logic [31:0] e_epc, e_rpc;
    logic        e_allow;
    logic [31:0] e_dpc;
    logic        e_dwe;
    logic [4:0]  e_dwnum;
    logic [31:0] e_dwdata;
    logic        e_drain;
    logic [31:0] e_drain_pc;
    logic        e_drain_we, e_drain_allow;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid   = 1'b0;
    in_lane_v  = '0;
    in_pc      = '0;
    in_dest    = '0;
    in_gr_we   = '0;
    in_result  = '0;
    in_exc     = '0;
    in_refetch = '0;
    in_ertn    = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid   = 1'b1;
    in_lane_v  = v.lane_v;
    in_pc      = {v.pc1, v.pc0};
    in_dest    = {v.d1, v.d0};
    in_gr_we   = v.gr_we;
    in_result  = {v.r1, v.r0};
    in_exc     = {v.x1, v.x0};
    in_refetch = v.refetch;
    in_ertn    = v.ertn;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Field order: lane_v pc0 pc1 d0 d1 gr_we r0 r1 x0 x1 refetch ertn |
    //   e_we flush taken idx ertn epc rpc allow dpc dwe dwnum dwdata drain drain_pc drain_we drain_allow
    // dual retire, no exceptions
    vecs[0]  = '{2'b11, 32'h1c000000, 32'h1c000004, 5'd3, 5'd4, 2'b11, 32'h100, 32'h200, 16'h0, 16'h0, 2'b00, 2'b00,
                 2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1c000000, 1'b1, 5'd3, 32'h100, 1'b1, 32'h1c000004, 1'b1, 1'b1};
    // lane 0 exception bit 5 kills lane 1
    vecs[1]  = '{2'b11, 32'h1c000010, 32'h1c000014, 5'd1, 5'd2, 2'b11, 32'hA1, 32'hA2, 16'h0020, 16'h0, 2'b00, 2'b00,
                 2'b00, 1'b1, 1'b1, 4'd5, 1'b0, 32'h1c000010, 32'h0, 1'b1, 32'h1c000010, 1'b0, 5'd1, 32'hA1, 1'b0, 32'h0, 1'b0, 1'b1};
    // lane 1 exception bits 3 and 7, lane 0 writes r5
    vecs[2]  = '{2'b11, 32'h1c000020, 32'h1c000024, 5'd5, 5'd6, 2'b11, 32'hAA, 32'h55, 16'h0, 16'h0088, 2'b00, 2'b00,
                 2'b01, 1'b1, 1'b1, 4'd3, 1'b0, 32'h1c000024, 32'h0, 1'b0, 32'h1c000020, 1'b1, 5'd5, 32'hAA, 1'b1, 32'h1c000024, 1'b0, 1'b0};
    // both lanes write r7: lane 1 wins
    vecs[3]  = '{2'b11, 32'h1c000030, 32'h1c000034, 5'd7, 5'd7, 2'b11, 32'h11, 32'h22, 16'h0, 16'h0, 2'b00, 2'b00,
                 2'b10, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1c000030, 1'b0, 5'd7, 32'h11, 1'b1, 32'h1c000034, 1'b1, 1'b1};
    // only lane 0 valid; invalid lane 1 carries an exception that must be ignored
    vecs[4]  = '{2'b01, 32'h1c000040, 32'h1c000044, 5'd8, 5'd9, 2'b11, 32'h1234, 32'h5678, 16'h0, 16'h0001, 2'b00, 2'b00,
                 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1c000040, 1'b1, 5'd8, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b1};
    // only lane 1 valid; trace shows lane 1
    vecs[5]  = '{2'b10, 32'h1c000050, 32'h1c000054, 5'd3, 5'd9, 2'b11, 32'h5050, 32'h9999, 16'h0002, 16'h0, 2'b00, 2'b00,
                 2'b10, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1c000054, 1'b1, 5'd9, 32'h9999, 1'b0, 32'h0, 1'b0, 1'b1};
    // both lanes write r0: no suppression
    vecs[6]  = '{2'b11, 32'h1c000060, 32'h1c000064, 5'd0, 5'd0, 2'b11, 32'h33, 32'h44, 16'h0, 16'h0, 2'b00, 2'b00,
                 2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1c000060, 1'b1, 5'd0, 32'h33, 1'b1, 32'h1c000064, 1'b1, 1'b1};
    // lane 0 ertn
    vecs[7]  = '{2'b11, 32'h1c000070, 32'h1c000074, 5'd1, 5'd10, 2'b10, 32'hE0, 32'hE4, 16'h0, 16'h0, 2'b00, 2'b01,
                 2'b00, 1'b1, 1'b0, 4'd0, 1'b1, 32'h1c000070, 32'h0, 1'b1, 32'h1c000070, 1'b0, 5'd1, 32'hE0, 1'b0, 32'h0, 1'b0, 1'b1};
    // lane 0 refetch still writes r2
    vecs[8]  = '{2'b11, 32'h1c000080, 32'h1c000084, 5'd2, 5'd11, 2'b11, 32'h77, 32'h78, 16'h0, 16'h0, 2'b01, 2'b00,
                 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 32'h1c000080, 32'h1c000080, 1'b1, 32'h1c000080, 1'b1, 5'd2, 32'h77, 1'b0, 32'h0, 1'b0, 1'b1};
    // highest-numbered cause bit alone
    vecs[9]  = '{2'b01, 32'h1c000090, 32'h1c000094, 5'd4, 5'd0, 2'b01, 32'h90, 32'h0, 16'h8000, 16'h0, 2'b00, 2'b00,
                 2'b00, 1'b1, 1'b1, 4'd15, 1'b0, 32'h1c000090, 32'h0, 1'b1, 32'h1c000090, 1'b0, 5'd4, 32'h90, 1'b0, 32'h0, 1'b0, 1'b1};
    // all cause bits: bit 0 wins
    vecs[10] = '{2'b11, 32'h1c0000a0, 32'h1c0000a4, 5'd4, 5'd5, 2'b11, 32'hA0, 32'hA4, 16'hffff, 16'h0, 2'b00, 2'b00,
                 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 32'h1c0000a0, 32'h0, 1'b1, 32'h1c0000a0, 1'b0, 5'd4, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b1};
    // lane 1 refetch: both write, flush, then drain with upstream held
    vecs[11] = '{2'b11, 32'h1c0000b0, 32'h1c0000b4, 5'd12, 5'd13, 2'b11, 32'hB0, 32'hB4, 16'h0, 16'h0, 2'b10, 2'b00,
                 2'b11, 1'b1, 1'b0, 4'd0, 1'b0, 32'h1c0000b4, 32'h1c0000b4, 1'b0, 32'h1c0000b0, 1'b1, 5'd12, 32'hB0, 1'b1, 32'h1c0000b4, 1'b1, 1'b0};

    // ---------------- reset ----------------
    drive_idle();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_allowin", 64'(in_allowin), 64'd1);
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_flush", 64'(flush), 64'd0);
    check("reset_epc", 64'(epc), 64'd0);
    check("reset_dbg_pc", 64'(debug_wb_pc), 64'h1bfffffc);
    check("reset_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    $display("txn reset: allowin=%0d dbg_pc=%08h", in_allowin, debug_wb_pc);
    @(negedge clk);
    resetn = 1'b1;

    // ---------------- table ----------------
    for (int k = 0; k < 12; k++) begin
      vec_t v;
      logic [31:0] last_pc;
      v = vecs[k];
      @(negedge clk);
      drive_vec(v);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rf_we", k), 64'(rf_we), 64'(v.e_we));
      check($sformatf("v%0d rf_waddr", k), 64'(rf_waddr), 64'({v.d1, v.d0}));
      check($sformatf("v%0d rf_wdata", k), 64'(rf_wdata), {v.r1, v.r0});
      check($sformatf("v%0d flush", k), 64'(flush), 64'(v.e_flush));
      check($sformatf("v%0d exc_taken", k), 64'(exc_taken), 64'(v.e_taken));
      check($sformatf("v%0d exc_idx", k), 64'(exc_idx), 64'(v.e_idx));
      check($sformatf("v%0d ertn_flush", k), 64'(ertn_flush), 64'(v.e_ertn));
      check($sformatf("v%0d epc", k), 64'(epc), 64'(v.e_epc));
      check($sformatf("v%0d refetch_pc", k), 64'(refetch_pc), 64'(v.e_rpc));
      check($sformatf("v%0d allowin", k), 64'(in_allowin), 64'(v.e_allow));
      check($sformatf("v%0d dbg_pc", k), 64'(debug_wb_pc), 64'(v.e_dpc));
      check($sformatf("v%0d dbg_we", k), 64'(debug_wb_rf_we), v.e_dwe ? 64'hf : 64'h0);
      check($sformatf("v%0d dbg_wnum", k), 64'(debug_wb_rf_wnum), 64'(v.e_dwnum));
      check($sformatf("v%0d dbg_wdata", k), 64'(debug_wb_rf_wdata), 64'(v.e_dwdata));
      $display("txn v%0d commit: rf_we=%b flush=%0d idx=%0d epc=%08h dbg_pc=%08h",
               k, rf_we, flush, exc_idx, epc, debug_wb_pc);
      @(negedge clk);
      drive_idle();
      last_pc = v.e_dpc;
      if (v.e_drain) begin
        @(posedge clk);
        #1;
        check($sformatf("v%0d drain rf_we", k), 64'(rf_we), 64'd0);
        check($sformatf("v%0d drain flush", k), 64'(flush), 64'd0);
        check($sformatf("v%0d drain dbg_pc", k), 64'(debug_wb_pc), 64'(v.e_drain_pc));
        check($sformatf("v%0d drain dbg_we", k), 64'(debug_wb_rf_we), v.e_drain_we ? 64'hf : 64'h0);
        check($sformatf("v%0d drain allowin", k), 64'(in_allowin), 64'(v.e_drain_allow));
        $display("txn v%0d drain: dbg_pc=%08h dbg_we=%h", k, debug_wb_pc, debug_wb_rf_we);
        last_pc = v.e_drain_pc;
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d empty allowin", k), 64'(in_allowin), 64'd1);
      check($sformatf("v%0d empty dbg_we", k), 64'(debug_wb_rf_we), 64'd0);
      check($sformatf("v%0d empty dbg_pc", k), 64'(debug_wb_pc), 64'(last_pc));
      check($sformatf("v%0d empty rf_we", k), 64'(rf_we), 64'd0);
    end

    // ---------------- flush discards the next input ----------------
    @(negedge clk);
    drive_vec(vecs[1]);
    @(posedge clk);
    #1;
    check("fd flush", 64'(flush), 64'd1);
    @(negedge clk);
    drive_vec(vecs[4]);
    check("fd allowin", 64'(in_allowin), 64'd1);
    @(posedge clk);
    #1;
    check("fd not_loaded rf_we", 64'(rf_we), 64'd0);
    check("fd not_loaded dbg_we", 64'(debug_wb_rf_we), 64'd0);
    check("fd no_second_flush", 64'(flush), 64'd0);
    $display("txn flush-discard: rf_we=%b dbg_we=%h", rf_we, debug_wb_rf_we);
    @(negedge clk);
    drive_idle();

    // ---------------- reset during DRAIN ----------------
    @(negedge clk);
    drive_vec(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("rd in_drain dbg_pc", 64'(debug_wb_pc), 64'h1c000004);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rd allowin", 64'(in_allowin), 64'd1);
    check("rd rf_we", 64'(rf_we), 64'd0);
    check("rd flush", 64'(flush), 64'd0);
    check("rd dbg_we", 64'(debug_wb_rf_we), 64'd0);
    check("rd dbg_pc", 64'(debug_wb_pc), 64'h1bfffffc);
    check("rd rf_wdata", 64'(rf_wdata), 64'd0);
    $display("txn reset-in-drain: allowin=%0d dbg_pc=%08h", in_allowin, debug_wb_pc);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rd after allowin", 64'(in_allowin), 64'd1);
    check("rd after dbg_we", 64'(debug_wb_rf_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
